// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MS memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_MS = 1'b1;

    // Bit positions inside the grant vector produced by arb_prio_sel.
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_MS = 1;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner selection: MS over IF unless the starvation limit is hit.
module arb_prio_sel
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       ms_req,
    input  logic       starve_hit,
    output logic [1:0] grant
);

    logic if_forced;

    always_comb begin
        if_forced     = if_req && starve_hit;
        grant         = '0;
        grant[GNT_MS] = ms_req && !if_forced;
        grant[GNT_IF] = if_req && (!ms_req || if_forced);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MS requesters onto one single-port, fixed-latency memory.
// Define MEM_ARB_STARVE_GUARD_EN to add the IF anti-starvation counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        if_rready,
    input  logic        ms_req,
    input  logic        ms_we,
    input  logic [3:0]  ms_wstrb,
    input  logic [31:0] ms_addr,
    input  logic [31:0] ms_wdata,
    output logic        ms_gnt,
    output logic        ms_rvalid,
    output logic [31:0] ms_rdata,
    input  logic        ms_rready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    arb_state_t  state, state_nxt;
    logic        owner;
    logic        is_store;
    logic [2:0]  lat_cnt;
    logic [31:0] rdata_q;
    logic        starve_hit;
    logic [1:0]  grant;
    logic        any_gnt;
    logic        owner_rready;

    arb_prio_sel u_prio (
        .if_req     (if_req),
        .ms_req     (ms_req),
        .starve_hit (starve_hit),
        .grant      (grant)
    );

    // Grants are combinational, so they must also be masked while reset is held.
    assign any_gnt      = (state == ARB_IDLE) && !rst && (|grant);
    assign owner_rready = (owner == OWN_MS) ? ms_rready : if_rready;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign starve_hit = (starve_cnt == 3'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (any_gnt) begin
            if (grant[GNT_MS] && if_req)
                starve_cnt <= starve_hit ? starve_cnt : starve_cnt + 3'd1;
            else
                starve_cnt <= '0;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_gnt)         state_nxt = ARB_WAIT;
            ARB_WAIT: if (lat_cnt == '0)   state_nxt = ARB_RESP;
            ARB_RESP: if (owner_rready)    state_nxt = ARB_IDLE;
            default:                       state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = any_gnt && grant[GNT_IF];
        ms_gnt    = any_gnt && grant[GNT_MS];
        mem_en    = any_gnt;
        mem_we    = ms_gnt && ms_we;
        mem_wstrb = ms_gnt ? ms_wstrb : '0;
        mem_wdata = ms_gnt ? ms_wdata : '0;
        mem_addr  = ms_gnt ? ms_addr : (if_gnt ? if_addr : '0);
        if_rvalid = (state == ARB_RESP) && (owner == OWN_IF);
        ms_rvalid = (state == ARB_RESP) && (owner == OWN_MS);
        if_rdata  = if_rvalid ? rdata_q : '0;
        ms_rdata  = ms_rvalid ? rdata_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_IF;
            is_store <= 1'b0;
            lat_cnt  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_gnt) begin
                        owner    <= grant[GNT_MS] ? OWN_MS : OWN_IF;
                        is_store <= grant[GNT_MS] && ms_we;
                        lat_cnt  <= LAT_INIT;
                    end
                end
                ARB_WAIT: begin
                    if (lat_cnt == '0) rdata_q <= is_store ? '0 : mem_rdata;
                    else               lat_cnt <= lat_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: timestamp-based reference model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned LAT  = 3;
    localparam int unsigned SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_rready;
    logic [31:0] if_addr, if_rdata;
    logic        ms_req, ms_we, ms_gnt, ms_rvalid, ms_rready;
    logic [3:0]  ms_wstrb;
    logic [31:0] ms_addr, ms_wdata, ms_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rready(if_rready),
        .ms_req(ms_req), .ms_we(ms_we), .ms_wstrb(ms_wstrb), .ms_addr(ms_addr),
        .ms_wdata(ms_wdata), .ms_gnt(ms_gnt), .ms_rvalid(ms_rvalid),
        .ms_rdata(ms_rdata), .ms_rready(ms_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory macro: reads return data LAT cycles after mem_en, garbage otherwise.
    logic [31:0] mem_arr [256];
    logic [31:0] shdw    [256];
    logic [31:0] pipe    [LAT];

    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : (32'hBAD0_0000 | cyc);
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    // Reference model: an access granted at model cycle S answers from S+LAT+1 until rready.
    logic        m_active = 1'b0;
    logic        m_owner_ms = 1'b0;
    int unsigned m_start = 0;
    logic [31:0] m_data = '0;
    int unsigned m_starve = 0;
    int unsigned mcyc = 0;

    always @(negedge clk) begin
        logic        e_ig, e_mg, e_en, e_we, e_iv, e_mv, e_memchk, hit;
        logic [3:0]  e_ws;
        logic [31:0] e_addr;
        int unsigned idx;
        e_ig = 0; e_mg = 0; e_en = 0; e_we = 0; e_iv = 0; e_mv = 0;
        e_ws = '0; e_addr = '0; e_memchk = 0; hit = 0;
        if (rst) begin
            m_active = 0;
            m_starve = 0;
            e_memchk = 1;
        end else if (!m_active) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            hit = (m_starve == SMAX);
`endif
            e_mg = ms_req && !(if_req && hit);
            e_ig = if_req && !e_mg;
            e_memchk = 1;
            if (e_mg || e_ig) begin
                e_en   = 1;
                e_addr = e_mg ? ms_addr : if_addr;
                e_we   = e_mg && ms_we;
                e_ws   = e_mg ? ms_wstrb : 4'h0;
                idx    = int'(e_addr[9:2]);
                m_active   = 1;
                m_start    = mcyc;
                m_owner_ms = e_mg;
                if (e_we) begin
                    m_data = '0;
                    for (int b = 0; b < 4; b++)
                        if (ms_wstrb[b]) shdw[idx][8*b +: 8] = ms_wdata[8*b +: 8];
                end else begin
                    m_data = shdw[idx];
                end
                if (e_mg && if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else                m_starve = 0;
            end
        end else if (mcyc >= m_start + LAT + 1) begin
            e_iv = !m_owner_ms;
            e_mv = m_owner_ms;
            if (m_owner_ms ? ms_rready : if_rready) m_active = 0;
        end
        chk("m_if_gnt", if_gnt, e_ig);
        chk("m_ms_gnt", ms_gnt, e_mg);
        chk("m_mem_en", mem_en, e_en);
        chk("m_if_rvalid", if_rvalid, e_iv);
        chk("m_ms_rvalid", ms_rvalid, e_mv);
        if (e_memchk) begin
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_wstrb", mem_wstrb, e_ws);
            chk("m_mem_addr", mem_addr, e_addr);
        end
        if (e_mg) chk("m_mem_wdata", mem_wdata, ms_wdata);
        if (e_iv) chk("m_if_rdata", if_rdata, m_data);
        if (e_mv) chk("m_ms_rdata", ms_rdata, m_data);
        mcyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_ms, output int unsigned t);
        int unsigned n = 0;
        @(negedge clk);
        while (!(is_ms ? ms_gnt : if_gnt) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(is_ms ? "ms_gnt_timeout" : "if_gnt_timeout", 32'(n < 50), 32'd1);
        t = cyc;
    endtask

    task automatic wait_rvalid(input bit is_ms, input int unsigned t0, output int unsigned lat);
        int unsigned n = 0;
        @(negedge clk);
        while (!(is_ms ? ms_rvalid : if_rvalid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(is_ms ? "ms_rvalid_timeout" : "if_rvalid_timeout", 32'(n < 50), 32'd1);
        lat = cyc - t0;
    endtask

    task automatic ms_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [31:0] exp, output int unsigned t0);
        int unsigned lat;
        ms_we = we; ms_addr = addr; ms_wdata = wdata; ms_wstrb = wstrb; ms_req = 1;
        wait_gnt(1, t0);
        chk("ms_grant_mem_we", mem_we, we);
        chk("ms_grant_mem_wstrb", mem_wstrb, wstrb);
        chk("ms_grant_mem_addr", mem_addr, addr);
        tick;
        ms_req = 0; ms_we = 0; ms_wstrb = '0;
        wait_rvalid(1, t0, lat);
        chk("ms_latency", lat, LAT + 1);
        chk("ms_rdata", ms_rdata, exp);
        chk("ms_if_rvalid_low", if_rvalid, 0);
        tick;
    endtask

    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp);
        int unsigned t0, lat;
        if_addr = addr; if_req = 1;
        wait_gnt(0, t0);
        chk("if_grant_mem_we", mem_we, 0);
        chk("if_grant_mem_wstrb", mem_wstrb, 0);
        chk("if_grant_mem_addr", mem_addr, addr);
        tick;
        if_req = 0;
        wait_rvalid(0, t0, lat);
        chk("if_latency", lat, LAT + 1);
        chk("if_rdata", if_rdata, exp);
        chk("if_ms_rvalid_low", ms_rvalid, 0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0, t1, lat, n;
        logic exp_if;
        rst = 1;
        if_req = 0; if_addr = '0; if_rready = 1;
        ms_req = 0; ms_we = 0; ms_wstrb = '0; ms_addr = '0; ms_wdata = '0; ms_rready = 1;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h5000_0000 + 32'(i);
            shdw[i]    = 32'h5000_0000 + 32'(i);
        end
        mem_arr[64]  = 32'hDEAD_BEEF; shdw[64]  = 32'hDEAD_BEEF;
        mem_arr[128] = 32'hCAFE_F00D; shdw[128] = 32'hCAFE_F00D;

        repeat (3) @(posedge clk);
        #1 ms_req = 1; if_req = 1;
        @(negedge clk);
        chk("rst_ms_gnt", ms_gnt, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ms_rvalid", ms_rvalid, 0);
        tick;
        ms_req = 0; if_req = 0; rst = 0;

        ms_access(0, 32'h100, '0, 4'h0, 32'hDEAD_BEEF, t0);

        ms_access(1, 32'h40, 32'hA5A5_A5A5, 4'hF, 32'h0, t0);
        ms_access(0, 32'h40, '0, 4'h0, 32'hA5A5_A5A5, t1);
        chk("back_to_back_spacing", t1 - t0, LAT + 2);
        ms_access(1, 32'h40, 32'h1234_5678, 4'b0011, 32'h0, t0);
        ms_access(0, 32'h40, '0, 4'h0, 32'hA5A5_5678, t0);

        if_access(32'h200, 32'hCAFE_F00D);

        // Backpressure on an IF response with an MS request waiting behind it.
        if_addr = 32'h200; if_req = 1; if_rready = 0;
        wait_gnt(0, t0);
        tick;
        if_req = 0;
        ms_we = 0; ms_addr = 32'h100; ms_req = 1;
        wait_rvalid(0, t0, lat);
        for (int k = 0; k < 10; k++) begin
            chk("bp_if_rvalid", if_rvalid, 1);
            chk("bp_if_rdata", if_rdata, 32'hCAFE_F00D);
            chk("bp_ms_gnt", ms_gnt, 0);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 if_rready = 1;
        @(negedge clk);
        chk("bp_release_ms_gnt", ms_gnt, 0);
        chk("bp_release_if_rvalid", if_rvalid, 1);
        @(negedge clk);
        chk("bp_after_ms_gnt", ms_gnt, 1);
        t0 = cyc;
        tick;
        ms_req = 0;
        wait_rvalid(1, t0, lat);
        chk("bp_ms_latency", lat, LAT + 1);
        chk("bp_ms_rdata", ms_rdata, 32'hDEAD_BEEF);
        tick;

        // Reset two cycles after a grant, while the access sits in its latency wait.
        ms_we = 0; ms_addr = 32'h40; ms_req = 1;
        wait_gnt(1, t0);
        tick;
        ms_req = 0; if_req = 1;
        tick;
        rst = 1;
        @(negedge clk);
        chk("midrst_if_gnt", if_gnt, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_if_rvalid", if_rvalid, 0);
        chk("midrst_ms_rvalid", ms_rvalid, 0);
        chk("midrst_ms_rdata", ms_rdata, 0);
        tick;
        rst = 0; if_req = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("postrst_no_rvalid", 32'(if_rvalid | ms_rvalid), 0);
        end
        tick;
        ms_access(0, 32'h100, '0, 4'h0, 32'hDEAD_BEEF, t0);

        // Both requesters held continuously for 20 grants.
        if_addr = 32'h200; ms_addr = 32'h100; ms_we = 0;
        if_req = 1; ms_req = 1;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            @(negedge clk);
            while (!(if_gnt || ms_gnt) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("starve_gnt_timeout", 32'(n < 50), 32'd1);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (i % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            chk("starve_if_winner", if_gnt, exp_if);
            chk("starve_ms_winner", ms_gnt, !exp_if);
            tick;
        end
        if_req = 0; ms_req = 0;
        repeat (LAT + 4) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port, fixed-latency memory between the instruction-fetch requester (IF) and the memory-stage load/store requester (MS). It sequences each access: grant, issue, latency wait, response hold. It returns read data or a store acknowledge to the owning requester. It sits between the fetch/mem pipeline stages and the unified memory macro. It allows the MS stage to stall (ready_go low) until its access completes.

## Interface
Parameters:
- MEM_LAT, 1: cycles from mem_en high to mem_rdata valid; legal range 1..7.
- STARVE_MAX, 4: consecutive MS grants, with IF pending, after which IF is forced to win.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_gnt.
- if_addr  in  32  fetch address, word aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid; held until if_rready.
- if_rdata  out  32  fetch read data.
- if_rready  in  1  fetch accepts response.
- ms_req  in  1  load/store request; held with attributes until ms_gnt.
- ms_we  in  1  1 = store, 0 = load.
- ms_wstrb  in  4  store byte enables.
- ms_addr  in  32  data address.
- ms_wdata  in  32  store data.
- ms_gnt  out  1  MS request accepted this cycle.
- ms_rvalid  out  1  MS response valid (load data or store ack); held until ms_rready.
- ms_rdata  out  32  load data; 0 for store acks.
- ms_rready  in  1  MS accepts response.
- mem_en, mem_we  out  1  memory access strobe / write enable.
- mem_wstrb  out  4  byte enables to memory.
- mem_addr, mem_wdata  out  32  memory address / write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- FSM states: IDLE, WAIT, RESP. Registers: owner (0 = IF, 1 = MS), lat_cnt (3 bits), rdata_q, starve_cnt (3 bits).
- IDLE, no request: all mem_* are 0.
- IDLE, any request: assert exactly one gnt combinationally. Drive mem_en=1 and the winner's addr/we/wstrb/wdata in the same cycle. For IF: mem_we=0, mem_wstrb=0. Latch owner and the store flag. Load lat_cnt=MEM_LAT-1. Go to WAIT.
- Priority: MS over IF. Exception: IF wins when both request and starve_cnt==STARVE_MAX.
- WAIT: mem_en=0. When lat_cnt==0, capture mem_rdata into rdata_q (0 if the access was a store) and go to RESP. Otherwise decrement lat_cnt.
- RESP: assert the owner's rvalid with rdata_q. On that requester's rready, go to IDLE. The other requester's rvalid stays 0.
- No grants outside IDLE. A request arriving in WAIT/RESP waits; the requester must hold it.
- starve_cnt updates only on a grant:
  - MS granted while if_req=1: increment, saturating at STARVE_MAX.
  - IF granted, or MS granted with if_req=0: clear.
- Only one outstanding access, ever.

## Timing
- Reset values: FSM=IDLE, owner=0, lat_cnt=0, rdata_q=0, starve_cnt=0. Every output is 0 during and after reset.
- Reset mid-access aborts the access; the response is dropped and the requesters must reissue. A store already issued to memory may have completed.
- Latency: grant cycle T; rvalid first high at T+MEM_LAT+1.
- Minimum cost per access is MEM_LAT+2 cycles when rready is already high in the RESP cycle (grant, MEM_LAT wait cycles, one RESP cycle, next grant in following IDLE).
- gnt and mem_* are combinational from req in IDLE. All other outputs are registered.
- rvalid stays high with stable rdata while rready=0; stall length is unbounded.
- Simultaneous if_req and ms_req in IDLE: the priority rule decides; the loser sees gnt=0 and holds.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starve_cnt and the forced-IF rule are present.
- MEM_ARB_STARVE_GUARD_EN undefined: strict MS-over-IF priority and no starve_cnt register. STARVE_MAX is ignored.

## Structure
- Shared package mem_arb_pkg holds:
  - FSM state encoding: ARB_IDLE=2'd0, ARB_WAIT=2'd1, ARB_RESP=2'd2.
  - Owner constants: OWN_IF=1'b0, OWN_MS=1'b1.
- One sub-module: arb_prio_sel, the combinational winner selection (inputs if_req, ms_req, starve_hit; output grant vector).
- Everything else stays in the top level.

## Test plan
- Single load, MEM_LAT=1: ms_req, ms_addr=0x100, memory returns 0xDEADBEEF -> ms_gnt in cycle 0, ms_rvalid in cycle 2 with ms_rdata=0xDEADBEEF; if_rvalid stays 0.
- Store then load, MEM_LAT=3: store 0xA5A5A5A5 to 0x40 with wstrb=0xF, then load 0x40 -> mem_we=1 and wstrb=0xF only in the store grant cycle; store ack has ms_rdata=0; load returns 0xA5A5A5A5; each response rises 4 cycles after its grant.
- Simultaneous requests, guard enabled, STARVE_MAX=4: if_req and ms_req held continuously -> MS wins 4 grants, IF wins the 5th, starve_cnt clears, then MS wins again.
- Backpressure: hold if_rready=0 for 10 cycles during an IF response -> if_rvalid and if_rdata stable; ms_req pending gets no ms_gnt until the cycle after if_rready=1.
- Reset mid-WAIT (MEM_LAT=5, rst asserted at grant+2) -> all outputs 0 immediately; after release, FSM in IDLE and a fresh request completes normally.
- Guard compiled out: if_req and ms_req held for 20 accesses -> IF never granted; all 20 grants go to MS.
